program_store: RTL and testbench
================================

PROGRAM_STORE -- requirements
Module: program_store

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of 16-bit instruction words (fixed at 8; address width 3).
REQ-002 SHALL have port clk  input  1  single system clock, all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port address  input  3  fetch address driven by the processor.
REQ-005 SHALL have port instruction  output  16  registered instruction word returned to the processor.
REQ-006 SHALL have port load_start  input  1  one-cycle pulse that begins or restarts a program load.
REQ-007 SHALL have port load_valid  input  1  load_data holds a valid word.
REQ-008 SHALL have port load_data  input  16  program word to store.
REQ-009 SHALL have port load_ready  output  1  block accepts a load word this cycle.
REQ-010 SHALL have port loaded  output  1  a full 8-word program is resident and being served.
REQ-011 SHALL have port load_count  output  4  number of words accepted in the current load, 0..8.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, RUN.
REQ-013 IDLE: load_start -> LOAD; otherwise remain in IDLE.
REQ-014 LOAD: load_ready = 1; a word is accepted only when load_valid && load_ready, on that edge.
REQ-015 Accepted word SHALL be written to mem[wr_ptr]; wr_ptr and load_count SHALL increment by 1.
REQ-016 The 8th accepted word (load_count 7->8) SHALL move the FSM LOAD -> RUN and set loaded = 1 on the same edge.
REQ-017 RUN: instruction SHALL equal mem[address] sampled at the previous edge (1-cycle read latency), updated every cycle.
REQ-018 In IDLE and LOAD, instruction SHALL be registered 16'h0000 (opcode 0, NOP).
REQ-019 load_ready SHALL be 0 in IDLE and RUN; load_valid outside LOAD SHALL be ignored.
REQ-020 load_start in RUN SHALL move to LOAD, clear loaded, and zero wr_ptr and load_count; memory contents SHALL be kept until overwritten.
REQ-021 load_start in LOAD SHALL restart the load: wr_ptr = 0, load_count = 0, state stays LOAD.
REQ-022 load_start and load_valid in the same LOAD cycle: load_start SHALL win and the word SHALL be dropped.
REQ-023 wr_ptr SHALL never wrap within a load; accepting the 8th word ends the load.
REQ-024 load_count SHALL hold at 8 throughout RUN.
REQ-025 address changes SHALL have no effect on the memory contents.

Reset
REQ-026 While rst is high, asynchronously: state = IDLE, instruction = 16'h0000, load_ready = 0, loaded = 0, load_count = 0, wr_ptr = 0, all 8 memory words = 16'h0000.
REQ-027 rst asserted mid-load or in RUN SHALL discard the partial or complete program.
REQ-028 After rst deasserts, the block SHALL remain in IDLE until load_start.

Verification
REQ-029 Reset, then load_start, then 8 back-to-back valid words 16'h1001..16'h1008 -> load_ready high for 8 cycles, loaded = 1 after the 8th edge, load_count = 8.
REQ-030 After REQ-029, drive address 0,3,7 on consecutive cycles -> instruction = 16'h1001, 16'h1004, 16'h1008, each one cycle late.
REQ-031 Load with load_valid toggling 1,0,1,0 and words 16'h2A00.. -> only valid cycles counted; load_count steps 1,1,2,2,...
REQ-032 After 4 words, assert load_start with load_valid = 1 and data 16'hFFFF -> load_count = 0 and 16'hFFFF not stored; the next 8 words fill addresses 0..7.
REQ-033 In RUN at address 5, pulse rst asynchronously between edges -> instruction = 16'h0000 and loaded = 0 immediately; a read of any address after a reload returns only newly loaded data.
REQ-034 In RUN, pulse load_start and stop after 3 new words -> instruction = 16'h0000, loaded = 0, load_ready = 1, load_count = 3.

Source files
------------

// File: rtl/program_store.sv
// program_store: 8 x 16-bit instruction store that is filled by a
// handshaked program load and then served to the processor with a
// one-cycle registered read.
//
// Ports:
//   clk          system clock, all state updates on posedge
//   rst          asynchronous active-high reset; clears state and memory
//   address      fetch address from the processor
//   instruction  registered instruction word (NOP = 0 unless in RUN)
//   load_start   one-cycle pulse that begins or restarts a program load
//   load_valid   load_data holds a valid word
//   load_data    program word to store
//   load_ready   block accepts a load word this cycle (high only in LOAD)
//   loaded       a full program is resident and being served
//   load_count   words accepted in the current load, 0..DEPTH
module program_store #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  address,
  output logic [15:0] instruction,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic        loaded,
  output logic [3:0]  load_count
);

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [DW-1:0] mem [DEPTH];

  // Word accepted on this edge: handshake completes and no restart pulse.
  logic accept;
  assign accept = (state == LOAD) && load_valid && load_ready && !load_start;

  // Last word of the program: the count reaches DEPTH on this edge.
  logic last_word;
  assign last_word = (load_count == CW'(DEPTH - 1));

  // Control FSM, load path and registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      instruction <= '0;
      load_ready  <= 1'b0;
      loaded      <= 1'b0;
      load_count  <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          instruction <= '0;
          if (load_start) begin
            state      <= LOAD;
            load_ready <= 1'b1;
            wr_ptr     <= '0;
            load_count <= '0;
          end
        end

        LOAD: begin
          instruction <= '0;
          if (load_start) begin
            // Restart wins over a simultaneous valid word; that word is dropped.
            wr_ptr     <= '0;
            load_count <= '0;
          end else if (accept) begin
            mem[wr_ptr] <= load_data;
            load_count  <= load_count + CW'(1);
            if (last_word) begin
              // Full program resident: stop accepting, start serving.
              state      <= RUN;
              load_ready <= 1'b0;
              loaded     <= 1'b1;
              wr_ptr     <= '0;
            end else begin
              wr_ptr <= wr_ptr + AW'(1);
            end
          end
        end

        RUN: begin
          if (load_start) begin
            // Reload keeps old memory contents until each word is overwritten.
            state       <= LOAD;
            load_ready  <= 1'b1;
            loaded      <= 1'b0;
            wr_ptr      <= '0;
            load_count  <= '0;
            instruction <= '0;
          end else begin
            instruction <= mem[address];
          end
        end

        default: begin
          state       <= IDLE;
          instruction <= '0;
          load_ready  <= 1'b0;
          loaded      <= 1'b0;
          load_count  <= '0;
          wr_ptr      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_store.sv
// tb_program_store: directed self-checking bench for program_store.
// Inputs are driven 1 time unit after the rising edge; outputs are
// checked at the same point, so each check sees the result of the
// preceding edge.
module tb_program_store;

  logic        clk;
  logic        rst;
  logic [2:0]  address;
  logic [15:0] instruction;
  logic        load_start;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        loaded;
  logic [3:0]  load_count;

  int total;
  int bad;

  program_store #(.DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .instruction (instruction),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .loaded      (loaded),
    .load_count  (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; address = '0; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    tick(); tick();
    total++; if (instruction !== 16'h0000) begin bad++; $display("FAIL reset_instruction: got %h want 0000", instruction); end
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL reset_load_ready: got %b want 0", load_ready); end
    total++; if (loaded !== 1'b0) begin bad++; $display("FAIL reset_loaded: got %b want 0", loaded); end
    total++; if (load_count !== 4'd0) begin bad++; $display("FAIL reset_load_count: got %0d want 0", load_count); end
    rst = 1'b0;
    // Stay idle without load_start even with valid words presented.
    load_valid = 1'b1; load_data = 16'hDEAD;
    tick(); tick();
    total++; if (load_ready !== 1'b0 || load_count !== 4'd0) begin bad++; $display("FAIL idle_hold: got ready=%b count=%0d want ready=0 count=0", load_ready, load_count); end
    load_valid = 1'b0;
  endtask

  task automatic test_basic_load();
    load_start = 1'b1; tick(); load_start = 1'b0;
    total++; if (load_ready !== 1'b1 || load_count !== 4'd0) begin bad++; $display("FAIL load_enter: got ready=%b count=%0d want ready=1 count=0", load_ready, load_count); end
    for (int i = 0; i < 8; i++) begin
      load_valid = 1'b1; load_data = 16'h1001 + 16'(i);
      total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_%0d: got %b want 1", i, load_ready); end
      tick();
      total++; if (load_count !== 4'(i + 1)) begin bad++; $display("FAIL basic_count_%0d: got %0d want %0d", i, load_count, i + 1); end
      total++; if (loaded !== (i == 7)) begin bad++; $display("FAIL basic_loaded_%0d: got %b want %b", i, loaded, (i == 7)); end
    end
    load_valid = 1'b0;
    total++; if (load_ready !== 1'b0 || instruction !== 16'h0000) begin bad++; $display("FAIL basic_run_entry: got ready=%b instr=%h want ready=0 instr=0000", load_ready, instruction); end
  endtask

  task automatic test_read_latency();
    address = 3'd0; tick();
    total++; if (instruction !== 16'h1001) begin bad++; $display("FAIL read_a0: got %h want 1001", instruction); end
    address = 3'd3;
    #2;
    total++; if (instruction !== 16'h1001) begin bad++; $display("FAIL read_latency: got %h want 1001", instruction); end
    tick();
    total++; if (instruction !== 16'h1004) begin bad++; $display("FAIL read_a3: got %h want 1004", instruction); end
    address = 3'd7; tick();
    total++; if (instruction !== 16'h1008) begin bad++; $display("FAIL read_a7: got %h want 1008", instruction); end
  endtask

  task automatic test_run_ignore();
    // load_valid in RUN must not disturb count or memory.
    load_valid = 1'b1; load_data = 16'hBEEF; address = 3'd0;
    tick(); tick();
    load_valid = 1'b0;
    total++; if (load_count !== 4'd8 || loaded !== 1'b1) begin bad++; $display("FAIL run_hold: got count=%0d loaded=%b want count=8 loaded=1", load_count, loaded); end
    total++; if (instruction !== 16'h1001) begin bad++; $display("FAIL run_mem_kept: got %h want 1001", instruction); end
  endtask

  task automatic test_toggle_valid();
    logic [15:0] word;
    word = 16'h2A00;
    load_start = 1'b1; tick(); load_start = 1'b0;
    total++; if (loaded !== 1'b0 || load_count !== 4'd0 || instruction !== 16'h0000) begin bad++; $display("FAIL toggle_enter: got loaded=%b count=%0d instr=%h want 0 0 0000", loaded, load_count, instruction); end
    for (int j = 0; j < 16; j++) begin
      load_valid = (j % 2 == 0);
      load_data  = load_valid ? word : 16'hFFFF;
      if (load_valid) word = word + 16'h1;
      tick();
      total++; if (load_count !== 4'(j / 2 + 1)) begin bad++; $display("FAIL toggle_count_%0d: got %0d want %0d", j, load_count, j / 2 + 1); end
    end
    load_valid = 1'b0;
    total++; if (loaded !== 1'b1) begin bad++; $display("FAIL toggle_loaded: got %b want 1", loaded); end
    for (int a = 0; a < 8; a += 3) begin
      address = 3'(a); tick();
      total++; if (instruction !== 16'h2A00 + 16'(a)) begin bad++; $display("FAIL toggle_read_%0d: got %h want %h", a, instruction, 16'h2A00 + 16'(a)); end
    end
  endtask

  task automatic test_restart_in_load();
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = 16'h3300 + 16'(i); tick();
    end
    total++; if (load_count !== 4'd4) begin bad++; $display("FAIL restart_pre: got %0d want 4", load_count); end
    load_start = 1'b1; load_valid = 1'b1; load_data = 16'hFFFF; tick();
    load_start = 1'b0;
    total++; if (load_count !== 4'd0 || load_ready !== 1'b1 || loaded !== 1'b0) begin bad++; $display("FAIL restart_clear: got count=%0d ready=%b loaded=%b want 0 1 0", load_count, load_ready, loaded); end
    for (int i = 0; i < 8; i++) begin
      load_valid = 1'b1; load_data = 16'h3400 + 16'(i); tick();
    end
    load_valid = 1'b0;
    total++; if (loaded !== 1'b1 || load_count !== 4'd8) begin bad++; $display("FAIL restart_done: got loaded=%b count=%0d want 1 8", loaded, load_count); end
    for (int a = 0; a < 8; a++) begin
      address = 3'(a); tick();
      total++; if (instruction !== 16'h3400 + 16'(a)) begin bad++; $display("FAIL restart_read_%0d: got %h want %h", a, instruction, 16'h3400 + 16'(a)); end
    end
  endtask

  task automatic test_async_reset_run();
    address = 3'd5; tick();
    total++; if (instruction !== 16'h3405) begin bad++; $display("FAIL arst_pre: got %h want 3405", instruction); end
    #2 rst = 1'b1;
    #1;
    total++; if (instruction !== 16'h0000 || loaded !== 1'b0) begin bad++; $display("FAIL arst_immediate: got instr=%h loaded=%b want 0000 0", instruction, loaded); end
    total++; if (load_count !== 4'd0 || load_ready !== 1'b0) begin bad++; $display("FAIL arst_ctrl: got count=%0d ready=%b want 0 0", load_count, load_ready); end
    #1 rst = 1'b0;
    tick();
    total++; if (instruction !== 16'h0000) begin bad++; $display("FAIL arst_idle_instr: got %h want 0000", instruction); end
    // Partial reload, then reset mid-load, then a full reload of fresh data.
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = 16'h4400 + 16'(i); tick();
    end
    load_valid = 1'b0;
    rst = 1'b1; #2; rst = 1'b0;
    total++; if (load_count !== 4'd0 || load_ready !== 1'b0) begin bad++; $display("FAIL arst_midload: got count=%0d ready=%b want 0 0", load_count, load_ready); end
    tick();
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      load_valid = 1'b1; load_data = 16'h5500 + 16'(i); tick();
    end
    load_valid = 1'b0;
    for (int a = 7; a >= 0; a -= 2) begin
      address = 3'(a); tick();
      total++; if (instruction !== 16'h5500 + 16'(a)) begin bad++; $display("FAIL arst_reload_read_%0d: got %h want %h", a, instruction, 16'h5500 + 16'(a)); end
    end
  endtask

  task automatic test_back_to_back();
    // Reload from RUN, stop after 3 words.
    address = 3'd2;
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = 16'h6600 + 16'(i); tick();
    end
    load_valid = 1'b0;
    tick();
    total++; if (instruction !== 16'h0000) begin bad++; $display("FAIL reload_instr: got %h want 0000", instruction); end
    total++; if (loaded !== 1'b0 || load_ready !== 1'b1) begin bad++; $display("FAIL reload_flags: got loaded=%b ready=%b want 0 1", loaded, load_ready); end
    total++; if (load_count !== 4'd3) begin bad++; $display("FAIL reload_count: got %0d want 3", load_count); end
    // Finish: 5 more words; old contents of 3..7 replaced, 0..2 are new.
    for (int i = 3; i < 8; i++) begin
      load_valid = 1'b1; load_data = 16'h6600 + 16'(i); tick();
    end
    load_valid = 1'b0;
    address = 3'd2; tick();
    total++; if (instruction !== 16'h6602) begin bad++; $display("FAIL reload_read_2: got %h want 6602", instruction); end
    address = 3'd6; tick();
    total++; if (instruction !== 16'h6606) begin bad++; $display("FAIL reload_read_6: got %h want 6606", instruction); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic_load();
    test_read_latency();
    test_run_ignore();
    test_toggle_valid();
    test_restart_in_load();
    test_async_reset_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
